switch_debounce: RTL

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce.sv | 92 +++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// switch_debounce
//   Debounces a raw mechanical switch. SW is brought into the clk domain through
//   a two-flop synchroniser. A new level is accepted only after it has been seen
//   for DELAY+1 consecutive synchronised samples: one edge enters the wait state,
//   then DELAY-1 edges count, then one more edge qualifies the level.
// Ports
//   clk     : single clock, rising edge
//   reset   : synchronous, active-high
//   SW      : raw asynchronous switch level
//   Y       : debounced level, decoded from the state register
//   CHANGED : one-cycle pulse in the first cycle Y shows a new value
//   BUSY    : high while a candidate level is being qualified
module switch_debounce #(
  parameter int DELAY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic SW,
  output logic Y,
  output logic CHANGED,
  output logic BUSY
);

  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DELAY - 1);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

  logic          r_s1, r_s2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_changed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_state   <= IDLE_LO;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_s1      <= SW;
      r_s2      <= r_s1;
      r_changed <= 1'b0;
      case (r_state)
        IDLE_LO: if (r_s2) begin
          r_state <= WAIT_HI;
          r_cnt   <= '0;
        end
        WAIT_HI: begin
          if (!r_s2) begin
            // bounce: abandon this attempt, next candidate restarts from zero
            r_state <= IDLE_LO;
            r_cnt   <= '0;
          end else if (r_cnt == CMAX) begin
            r_state   <= IDLE_HI;
            r_cnt     <= '0;
            r_changed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE_HI: if (!r_s2) begin
          r_state <= WAIT_LO;
          r_cnt   <= '0;
        end
        WAIT_LO: begin
          if (r_s2) begin
            r_state <= IDLE_HI;
            r_cnt   <= '0;
          end else if (r_cnt == CMAX) begin
            r_state   <= IDLE_LO;
            r_cnt     <= '0;
            r_changed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE_LO;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Y keeps the old level while a drop is being qualified (WAIT_LO)
  assign Y       = (r_state == IDLE_HI) || (r_state == WAIT_LO);
  assign BUSY    = (r_state == WAIT_HI) || (r_state == WAIT_LO);
  assign CHANGED = r_changed;

endmodule
